// File: rtl/rf_write_checker_if.sv
`timescale 1ns/1ps
// rf_write_checker_if: expected-table load, run control, rf write tap and verdict signals of rf_write_checker.
// Defining RF_CHK_MASK_EN adds the per-entry exp_mask load field.
interface rf_write_checker_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 8,
    parameter int TMO_W  = 16
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    logic              exp_we;
    logic [IW-1:0]     exp_idx;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
`ifdef RF_CHK_MASK_EN
    logic [DATA_W-1:0] exp_mask;
`endif
    logic [CW-1:0]     exp_count;
    logic [TMO_W-1:0]  tmo_cycles;
    logic              start;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              busy;
    logic              done;
    logic              pass;
    logic              fail;
    logic              timeout;
    logic [IW-1:0]     err_idx;
    logic [DATA_W-1:0] err_data;
    logic [CW-1:0]     match_cnt;

    modport master (
        output exp_we, exp_idx, exp_addr, exp_data,
`ifdef RF_CHK_MASK_EN
        output exp_mask,
`endif
        output exp_count, tmo_cycles, start, rf_we, rf_waddr, rf_wdata,
        input  busy, done, pass, fail, timeout, err_idx, err_data, match_cnt
    );

    modport slave (
        input  exp_we, exp_idx, exp_addr, exp_data,
`ifdef RF_CHK_MASK_EN
        input  exp_mask,
`endif
        input  exp_count, tmo_cycles, start, rf_we, rf_waddr, rf_wdata,
        output busy, done, pass, fail, timeout, err_idx, err_data, match_cnt
    );
endinterface

// File: rtl/rf_write_checker.sv
`timescale 1ns/1ps
// rf_write_checker: compares the live register-file write stream against a programmed table of
// expected (addr, data) writes, in order, and reports pass, mismatch (with index/data) or timeout.
// Defining RF_CHK_MASK_EN adds a per-entry don't-care data mask (mask bit 0 = ignore that bit).
module rf_write_checker #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 8,
    parameter int TMO_W  = 16
) (
    input logic clk,
    input logic rst,
    rf_write_checker_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {IDLE, ARMED, PASS, FAIL} state_t;

    state_t            state;
    logic [ADDR_W-1:0] t_addr [DEPTH];
    logic [DATA_W-1:0] t_data [DEPTH];
`ifdef RF_CHK_MASK_EN
    logic [DATA_W-1:0] t_mask [DEPTH];
`endif
    logic [CW-1:0]     lim;
    logic [CW-1:0]     match_cnt;
    logic [TMO_W-1:0]  tmo_lim;
    logic [TMO_W-1:0]  timer;
    logic              busy;
    logic              done;
    logic              pass;
    logic              fail;
    logic              timeout;
    logic [IW-1:0]     err_idx;
    logic [DATA_W-1:0] err_data;
    logic [IW-1:0]     cur;
    logic              wr;
    logic              hit;
    logic              expire;
    logic              arm;

    // Decode the current rf write against the entry being waited on; x0 writes never count.
    always_comb begin
        cur    = match_cnt[IW-1:0];
        wr     = bus.rf_we && bus.rf_waddr != '0;
`ifdef RF_CHK_MASK_EN
        hit    = bus.rf_waddr == t_addr[cur] && ((bus.rf_wdata ^ t_data[cur]) & t_mask[cur]) == '0;
`else
        hit    = bus.rf_waddr == t_addr[cur] && bus.rf_wdata == t_data[cur];
`endif
        expire = tmo_lim != '0 && timer + 1'b1 == tmo_lim;
        arm    = bus.start && state != ARMED;
    end

    // Expected table: loadable whenever no check is running, deliberately kept across reset.
    always_ff @(posedge clk) begin
        if (bus.exp_we && state != ARMED) begin
            t_addr[bus.exp_idx] <= bus.exp_addr;
            t_data[bus.exp_idx] <= bus.exp_data;
`ifdef RF_CHK_MASK_EN
            t_mask[bus.exp_idx] <= bus.exp_mask;
`endif
        end
    end

    // Check sequencer with registered verdict flags; a match beats a same-cycle timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lim       <= '0;
            tmo_lim   <= '0;
            match_cnt <= '0;
            timer     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            err_idx   <= '0;
            err_data  <= '0;
        end else if (arm) begin
            lim       <= bus.exp_count > CW'(DEPTH) ? CW'(DEPTH) : bus.exp_count;
            tmo_lim   <= bus.tmo_cycles;
            match_cnt <= '0;
            timer     <= '0;
            state     <= bus.exp_count == '0 ? PASS : ARMED;
            busy      <= bus.exp_count != '0;
            done      <= bus.exp_count == '0;
            pass      <= bus.exp_count == '0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            err_idx   <= '0;
            err_data  <= '0;
        end else if (state == ARMED) begin
            if (wr && hit) begin
                match_cnt <= match_cnt + 1'b1;
                timer     <= '0;
                if (match_cnt + 1'b1 == lim) begin
                    state <= PASS;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= 1'b1;
                end
            end else if (wr || expire) begin
                state    <= FAIL;
                busy     <= 1'b0;
                done     <= 1'b1;
                fail     <= 1'b1;
                timeout  <= !wr;
                err_idx  <= cur;
                err_data <= wr ? bus.rf_wdata : '0;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.pass      = pass;
    assign bus.fail      = fail;
    assign bus.timeout   = timeout;
    assign bus.err_idx   = err_idx;
    assign bus.err_data  = err_data;
    assign bus.match_cnt = match_cnt;
endmodule

// File: tb/tb_rf_write_checker.sv
`timescale 1ns/1ps
// tb_rf_write_checker: directed plus randomized scoreboard bench for rf_write_checker.
module tb_rf_write_checker;
    localparam int DATA_W = 32, ADDR_W = 5, DEPTH = 8, TMO_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rf_write_checker_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TMO_W(TMO_W)) bus ();
    rf_write_checker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TMO_W(TMO_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        ld;
        logic        st;
    } item_t;

    typedef struct {
        logic        pass;
        logic        fail;
        logic        tmo;
        logic [2:0]  idx;
        logic [31:0] data;
        logic [3:0]  mcnt;
        int          cyc;
        int          jd;
    } exp_t;

    item_t       stim[$];
    exp_t        sb[$];
    exp_t        me;
    logic [4:0]  ta [DEPTH];
    logic [31:0] td [DEPTH];
    logic [31:0] tm [DEPTH];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        pd = 1'b0;
    logic        ps = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [63:0] pack_out();
        return {20'b0, bus.done, bus.pass, bus.fail, bus.timeout, bus.busy,
                bus.err_idx, bus.err_data, bus.match_cnt};
    endfunction

    function automatic logic [63:0] pack_exp(exp_t e);
        return {20'b0, 1'b1, e.pass, e.fail, e.tmo, 1'b0, e.idx, e.data, e.mcnt};
    endfunction

    // Reference: walk the rf write stream cycle by cycle (idle beyond its end) applying the checking rules.
    function automatic exp_t model(int n, int tmo, int base);
        exp_t  e;
        item_t s;
        int    idx = 0;
        int    gap = 0;
        e = '{default: 0};
        if (n == 0) begin
            e.pass = 1'b1;
            e.cyc  = base + 1;
            e.jd   = -1;
            return e;
        end
        for (int j = 0; j < 2000; j++) begin
            s = '{default: 0};
            if (j < stim.size()) s = stim[j];
            e.jd  = j;
            e.cyc = base + 2 + j;
            if (s.we && s.addr != 0) begin
                if (s.addr == ta[idx] && ((s.data ^ td[idx]) & tm[idx]) == 0) begin
                    idx++;
                    gap = 0;
                    if (idx == n) begin
                        e.pass = 1'b1;
                        e.mcnt = 4'(idx);
                        return e;
                    end
                end else begin
                    e.fail = 1'b1;
                    e.idx  = 3'(idx);
                    e.data = s.data;
                    e.mcnt = 4'(idx);
                    return e;
                end
            end else begin
                gap++;
                if (tmo != 0 && gap == tmo) begin
                    e.fail = 1'b1;
                    e.tmo  = 1'b1;
                    e.idx  = 3'(idx);
                    e.mcnt = 4'(idx);
                    return e;
                end
            end
        end
        e.jd = -2;
        return e;
    endfunction

    task automatic load(int i, logic [4:0] a, logic [31:0] d, logic [31:0] m);
        @(posedge clk); #1;
        bus.exp_we   = 1'b1;
        bus.exp_idx  = 3'(i);
        bus.exp_addr = a;
        bus.exp_data = d;
        ta[i] = a;
        td[i] = d;
`ifdef RF_CHK_MASK_EN
        bus.exp_mask = m;
        tm[i] = m;
`else
        tm[i] = m | 32'hFFFF_FFFF;
`endif
    endtask

    task automatic add(logic we, logic [4:0] a, logic [31:0] d);
        stim.push_back('{we: we, addr: a, data: d, ld: 1'b0, st: 1'b0});
    endtask

    // Random stream: gaps of idle/x0 traffic (sometimes around the timeout), then in-order writes, some corrupted.
    task automatic gen(int n, int tmo);
        stim.delete();
        for (int k = 0; k < n; k++) begin
            int gap = ($urandom_range(0, 7) == 0 && tmo != 0) ? tmo + $urandom_range(0, 2) - 1 : $urandom_range(0, 3);
            item_t w;
            for (int g = 0; g < gap; g++) begin
                item_t s;
                s.we   = 1'($urandom_range(0, 1));
                s.addr = s.we ? 5'd0 : 5'($urandom);
                s.data = $urandom;
                s.ld   = $urandom_range(0, 9) == 0;
                s.st   = $urandom_range(0, 15) == 0;
                stim.push_back(s);
            end
            w.we   = 1'b1;
            w.addr = ta[k];
            w.data = td[k] ^ ($urandom & ~tm[k]);
            w.ld   = 1'b0;
            w.st   = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 1) w.addr = 5'((w.addr % 31) + 1);
                else w.data = w.data ^ (32'd1 << $urandom_range(0, 31));
            end
            stim.push_back(w);
        end
    endtask

    task automatic run(int cnt, int tmo);
        exp_t e;
        int n = cnt > DEPTH ? DEPTH : cnt;
        @(posedge clk); #1;
        e = model(n, tmo, cyc);
        for (int j = e.jd + 1; j < stim.size(); j++) begin
            if (j >= 0) begin
                stim[j].ld = 1'b0;
                stim[j].st = 1'b0;
            end
        end
        sb.push_back(e);
        bus.exp_we     = 1'b0;
        bus.exp_count  = 4'(cnt);
        bus.tmo_cycles = 16'(tmo);
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        foreach (stim[j]) begin
            bus.rf_we    = stim[j].we;
            bus.rf_waddr = stim[j].addr;
            bus.rf_wdata = stim[j].data;
            bus.start    = stim[j].st;
            bus.exp_we   = stim[j].ld;
            bus.exp_idx  = 3'($urandom);
            bus.exp_addr = 5'($urandom);
            bus.exp_data = $urandom;
            @(posedge clk); #1;
        end
        bus.rf_we  = 1'b0;
        bus.start  = 1'b0;
        bus.exp_we = 1'b0;
        for (int k = 0; k < 300 && sb.size() != 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL verdict_wait: done never rose within 300 cycles, %0d verdicts pending", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
        check("hold", pack_out(), pack_exp(e));
    endtask

    // Monitor: each fresh verdict (done rising, or done right after a start) is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && bus.done && (!pd || ps)) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_verdict: got %h with nothing expected", pack_out());
                end else begin
                    me = sb.pop_front();
                    check("verdict", pack_out(), pack_exp(me));
                    check("latency", 64'(cyc), 64'(me.cyc));
                end
            end
            pd = bus.done;
            ps = bus.start;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        int tmo;
        bus.exp_we = 1'b0; bus.exp_idx = '0; bus.exp_addr = '0; bus.exp_data = '0;
`ifdef RF_CHK_MASK_EN
        bus.exp_mask = '0;
`endif
        bus.exp_count = '0; bus.tmo_cycles = '0; bus.start = 1'b0;
        bus.rf_we = 1'b0; bus.rf_waddr = '0; bus.rf_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", pack_out(), 64'd0);
        rst = 1'b1;

        load(0, 5'd5, 32'h4, '1);
        stim.delete(); add(0, 5'd0, 0); add(0, 5'd0, 0); add(1, 5'd5, 32'h4);
        run(1, 20);

        load(0, 5'd5, 32'h4, '1);
        stim.delete(); add(1, 5'd5, 32'h6);
        run(1, 20);

        load(0, 5'd5, 32'h4, '1); load(1, 5'd6, 32'h7, '1);
        stim.delete(); add(1, 5'd5, 32'h4);
        run(2, 10);

        load(0, 5'd5, 32'h4, '1); load(1, 5'd9, 32'h33, '1);
        stim.delete(); add(1, 5'd5, 32'h4); add(1, 5'd0, 32'hFF); add(1, 5'd9, 32'h33);
        run(2, 0);

        stim.delete();
        run(0, 5);

        for (int i = 0; i < DEPTH; i++) load(i, 5'(i + 10), 32'(i * 3 + 1), '1);
        stim.delete();
        for (int i = 0; i < DEPTH; i++) add(1, 5'(i + 10), 32'(i * 3 + 1));
        run(15, 0);

        load(0, 5'd3, 32'h11, '1); load(1, 5'd7, 32'h22, '1);
        @(posedge clk); #1;
        bus.exp_we = 1'b0; bus.exp_count = 4'd2; bus.tmo_cycles = '0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.rf_we = 1'b1; bus.rf_waddr = 5'd3; bus.rf_wdata = 32'h11;
        @(posedge clk); #1;
        bus.rf_we = 1'b0;
        @(posedge clk); #1;
        check("armed_mid", {59'd0, bus.busy, bus.match_cnt}, {59'd0, 1'b1, 4'd1});
        #2 rst = 1'b0;
        #1 check("async_reset", pack_out(), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        stim.delete(); add(1, 5'd3, 32'h11); add(1, 5'd7, 32'h22);
        run(2, 0);

`ifdef RF_CHK_MASK_EN
        load(0, 5'd5, 32'h10, 32'hF0);
        stim.delete(); add(1, 5'd5, 32'h1F);
        run(1, 0);
`endif

        repeat (60) begin
            for (int i = 0; i < DEPTH; i++) load(i, 5'($urandom_range(1, 31)), $urandom, $urandom);
            cnt = $urandom_range(0, 9) == 0 ? $urandom_range(DEPTH + 1, 15) : $urandom_range(0, DEPTH);
            tmo = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 12);
            gen(cnt > DEPTH ? DEPTH : cnt, tmo);
            run(cnt, tmo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
